// File: rtl/tspi_frame_rx.sv
// Three-line VFD serial receiver: deserialises one display frame, streams pixel samples with
// row/slot coordinates and reports the grid-select field and frame status on each LAT rise.
module tspi_frame_rx #(
  parameter int unsigned FRAME_BITS  = 288,
  parameter int unsigned PIX_BITS    = 234,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           SCK,
  input  logic [2:0]                     SDAT,
  input  logic                           LAT,
  input  logic                           BLK,
  output logic                           px_valid,
  output logic [2:0]                     px_data,
  output logic [5:0]                     px_row,
  output logic [2:0]                     px_slot,
  output logic [FRAME_BITS-PIX_BITS-1:0] grid_mask,
  output logic [5:0]                     grid_first,
  output logic [5:0]                     grid_cnt,
  output logic                           frame_done,
  output logic [1:0]                     frame_err,
  output logic                           blank
);

  localparam int unsigned GRID_BITS = FRAME_BITS - PIX_BITS;
  localparam logic [8:0]  FRAME_W   = 9'(FRAME_BITS);
  localparam logic [8:0]  PIX_W     = 9'(PIX_BITS);

  typedef enum logic [1:0] {StIdle, StShift, StOverrun} state_e;

  logic [SYNC_STAGES-1:0]      sck_sync, lat_sync, blk_sync;
  logic [SYNC_STAGES-1:0][2:0] sdat_sync;
  logic                        sck_prev_q, lat_prev_q;
  logic                        sck_s, lat_s;
  logic [2:0]                  sdat_s;
  logic                        sck_rise, lat_rise;

  state_e                 state_q, state_post, state_d;
  logic [8:0]             bit_cnt_q, bit_cnt_post;
  logic [5:0]             row_q, row_post;
  logic [2:0]             slot_q, slot_post;
  logic [5:0]             gidx_q, gidx_post;
  logic [GRID_BITS-1:0]   shadow_q, shadow_post;
  logic                   mism_q, mism_post;
  logic                   accept, pix_hit;
  logic [5:0]             first_c, cnt_c;
  logic [1:0]             err_c;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign lat_s    = lat_sync[SYNC_STAGES-1];
  assign sdat_s   = sdat_sync[SYNC_STAGES-1];
  assign blank    = blk_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign lat_rise = lat_s & ~lat_prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_sync   <= '0;
      lat_sync   <= '0;
      blk_sync   <= '0;
      sdat_sync  <= '0;
      sck_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], SCK};
      lat_sync   <= {lat_sync[SYNC_STAGES-2:0], LAT};
      blk_sync   <= {blk_sync[SYNC_STAGES-2:0], BLK};
      sdat_sync  <= {sdat_sync[SYNC_STAGES-2:0], SDAT};
      sck_prev_q <= sck_s;
      lat_prev_q <= lat_s;
    end
  end

  always_comb begin
    state_post = state_q;
    case (state_q)
      StIdle:  if (sck_rise) state_post = StShift;
      StShift: if (sck_rise && bit_cnt_q == FRAME_W) state_post = StOverrun;
      default: ;
    endcase
    state_d = lat_rise ? StIdle : state_post;
  end

  // "post" values include the current edge, so an edge coinciding with LAT lands in the ending frame.
  always_comb begin
    accept       = sck_rise && (state_q != StOverrun) && (bit_cnt_q != FRAME_W);
    pix_hit      = accept && (bit_cnt_q < PIX_W);
    bit_cnt_post = bit_cnt_q;
    row_post     = row_q;
    slot_post    = slot_q;
    gidx_post    = gidx_q;
    shadow_post  = shadow_q;
    mism_post    = mism_q;
    if (accept) bit_cnt_post = bit_cnt_q + 9'd1;
    if (pix_hit) begin
      if (slot_q == 3'd5) begin
        slot_post = 3'd0;
        row_post  = row_q + 6'd1;
      end else begin
        slot_post = slot_q + 3'd1;
      end
    end else if (accept) begin
      shadow_post[gidx_q] = sdat_s[0];
      gidx_post           = gidx_q + 6'd1;
      if (sdat_s != 3'b000 && sdat_s != 3'b111) mism_post = 1'b1;
    end
  end

  always_comb begin
    first_c = '0;
    cnt_c   = '0;
    for (int i = GRID_BITS - 1; i >= 0; i--) begin
      if (shadow_post[i]) first_c = 6'(i + 1);
      cnt_c = cnt_c + {5'd0, shadow_post[i]};
    end
    if (state_post == StOverrun)   err_c = 2'b10;
    else if (bit_cnt_post < FRAME_W) err_c = 2'b01;
    else if (mism_post)            err_c = 2'b11;
    else                           err_c = 2'b00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      gidx_q    <= '0;
      shadow_q  <= '0;
      mism_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= lat_rise ? '0 : bit_cnt_post;
      row_q     <= lat_rise ? '0 : row_post;
      slot_q    <= lat_rise ? '0 : slot_post;
      gidx_q    <= lat_rise ? '0 : gidx_post;
      shadow_q  <= lat_rise ? '0 : shadow_post;
      mism_q    <= lat_rise ? 1'b0 : mism_post;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      px_valid   <= 1'b0;
      px_data    <= '0;
      px_row     <= '0;
      px_slot    <= '0;
      frame_done <= 1'b0;
      frame_err  <= '0;
      grid_mask  <= '0;
      grid_first <= '0;
      grid_cnt   <= '0;
    end else begin
      px_valid   <= pix_hit;
      frame_done <= lat_rise;
      if (pix_hit) begin
        px_data <= sdat_s;
        px_row  <= row_q;
        px_slot <= slot_q;
      end
      if (lat_rise) begin
        grid_mask  <= shadow_post;
        grid_first <= first_c;
        grid_cnt   <= cnt_c;
        frame_err  <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_tspi_frame_rx.sv
// Directed bench for tspi_frame_rx: table of whole-frame vectors plus hand sequences for
// pixel ordering, mid-frame reset, coincident SCK/LAT and blanking.
module tb_tspi_frame_rx;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SCK = 1'b0;
  logic [2:0]  SDAT = 3'b000;
  logic        LAT = 1'b0;
  logic        BLK = 1'b0;
  logic        px_valid;
  logic [2:0]  px_data;
  logic [5:0]  px_row;
  logic [2:0]  px_slot;
  logic [53:0] grid_mask;
  logic [5:0]  grid_first;
  logic [5:0]  grid_cnt;
  logic        frame_done;
  logic [1:0]  frame_err;
  logic        blank;

  tspi_frame_rx dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SCK        (SCK),
    .SDAT       (SDAT),
    .LAT        (LAT),
    .BLK        (BLK),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_row     (px_row),
    .px_slot    (px_slot),
    .grid_mask  (grid_mask),
    .grid_first (grid_first),
    .grid_cnt   (grid_cnt),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .blank      (blank)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor, sampled on the falling edge.
  int          px_cnt = 0;
  int          done_cnt = 0;
  logic [2:0]  px_d_arr [8192];
  logic [5:0]  px_r_arr [8192];
  logic [2:0]  px_s_arr [8192];
  logic [1:0]  cap_err;
  logic [53:0] cap_mask;
  logic [5:0]  cap_first, cap_cnt;

  always @(negedge CLK) begin
    if (px_valid) begin
      if (px_cnt < 8192) begin
        px_d_arr[px_cnt] = px_data;
        px_r_arr[px_cnt] = px_row;
        px_s_arr[px_cnt] = px_slot;
      end
      px_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      cap_err   = frame_err;
      cap_mask  = grid_mask;
      cap_first = grid_first;
      cap_cnt   = grid_cnt;
    end
  end

  typedef struct {
    int          edges;
    logic [53:0] grid;
    int          bad_bit;
    logic [1:0]  exp_err;
    logic [53:0] exp_mask;
    logic [5:0]  exp_first;
    logic [5:0]  exp_cnt;
    int          exp_px;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic [2:0] d);
    SDAT = d;
    SCK  = 1'b0;
    tick(3);
    SCK  = 1'b1;
    tick(3);
  endtask

  task automatic run_frame(input int edges, input logic [53:0] grid, input int bad_bit);
    logic [2:0] d;
    for (int i = 0; i < edges; i++) begin
      if (i < 234) begin
        d = 3'(i % 6);
      end else if (i - 234 < 54) begin
        d = grid[i-234] ? 3'b111 : 3'b000;
        if (i - 234 == bad_bit) d = 3'b101;
      end else begin
        d = 3'b000;
      end
      send_bit(d);
    end
  endtask

  // Expects LAT already raised by the caller.
  task automatic wait_done();
    int   start;
    logic seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (done_cnt != start) seen = 1'b1;
    end
    chk("frame_done_seen", 64'(seen), 64'd1);
    LAT = 1'b0;
    tick(4);
    chk("frame_done_once", 64'(done_cnt - start), 64'd1);
  endtask

  task automatic chk_frame(input string tag, input logic [1:0] err, input logic [53:0] mask,
                           input logic [5:0] first, input logic [5:0] cnt, input int px,
                           input int base);
    chk({tag, ".err"},   64'(cap_err),   64'(err));
    chk({tag, ".mask"},  64'(cap_mask),  64'(mask));
    chk({tag, ".first"}, 64'(cap_first), 64'(first));
    chk({tag, ".cnt"},   64'(cap_cnt),   64'(cnt));
    chk({tag, ".px"},    64'(px_cnt - base), 64'(px));
  endtask

  initial begin
    int          base;
    int          bad;
    logic [53:0] m;

    vecs[0] = '{288, 54'h30, -1, 2'b00, 54'h30, 6'd5, 6'd2, 234};
    vecs[1] = '{200, 54'h0, -1, 2'b01, 54'h0, 6'd0, 6'd0, 200};
    vecs[2] = '{288, 54'h1, -1, 2'b00, 54'h1, 6'd1, 6'd1, 234};
    vecs[3] = '{300, 54'h0, -1, 2'b10, 54'h0, 6'd0, 6'd0, 234};
    vecs[4] = '{288, 54'h0, 10, 2'b11, 54'h400, 6'd11, 6'd1, 234};
    vecs[5] = '{0, 54'h0, -1, 2'b01, 54'h0, 6'd0, 6'd0, 0};
    vecs[6] = '{288, 54'h3FFFFFFFFFFFFF, -1, 2'b00, 54'h3FFFFFFFFFFFFF, 6'd1, 6'd54, 234};
    vecs[7] = '{250, 54'h8, -1, 2'b01, 54'h8, 6'd4, 6'd1, 234};
    vecs[8] = '{290, 54'h20000000000000, -1, 2'b10, 54'h20000000000000, 6'd54, 6'd1, 234};

    tick(3);
    RST_N = 1'b1;
    tick(3);
    chk("rst.px_valid",   64'(px_valid),   64'd0);
    chk("rst.frame_done", 64'(frame_done), 64'd0);
    chk("rst.frame_err",  64'(frame_err),  64'd0);
    chk("rst.grid_mask",  64'(grid_mask),  64'd0);
    chk("rst.grid_first", 64'(grid_first), 64'd0);
    chk("rst.grid_cnt",   64'(grid_cnt),   64'd0);
    chk("rst.blank",      64'(blank),      64'd0);

    for (int v = 0; v < 9; v++) begin
      base = px_cnt;
      run_frame(vecs[v].edges, vecs[v].grid, vecs[v].bad_bit);
      LAT = 1'b1;
      wait_done();
      chk_frame($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_mask, vecs[v].exp_first,
                vecs[v].exp_cnt, vecs[v].exp_px, base);
      if (v == 0) begin
        chk("order.p0.row",   64'(px_r_arr[base]),       64'd0);
        chk("order.p0.slot",  64'(px_s_arr[base]),       64'd0);
        chk("order.p6.row",   64'(px_r_arr[base+6]),     64'd1);
        chk("order.p6.slot",  64'(px_s_arr[base+6]),     64'd0);
        chk("order.p233.row", 64'(px_r_arr[base+233]),   64'd38);
        chk("order.p233.slot", 64'(px_s_arr[base+233]),  64'd5);
        chk("order.p233.data", 64'(px_d_arr[base+233]),  64'd5);
        bad = 0;
        for (int k = 0; k < 234; k++) begin
          if (px_r_arr[base+k] !== 6'(k / 6) || px_s_arr[base+k] !== 3'(k % 6) ||
              px_d_arr[base+k] !== 3'(k % 6)) bad++;
        end
        chk("order.all_bad", 64'(bad), 64'd0);
      end
    end

    // Reset in the middle of a frame, then a clean frame with grids 52 and 53.
    run_frame(100, 54'h0, -1);
    RST_N = 1'b0;
    tick(1);
    chk("midrst.px_row",    64'(px_row),    64'd0);
    chk("midrst.px_data",   64'(px_data),   64'd0);
    chk("midrst.grid_mask", 64'(grid_mask), 64'd0);
    chk("midrst.frame_err", 64'(frame_err), 64'd0);
    chk("midrst.grid_cnt",  64'(grid_cnt),  64'd0);
    SCK = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(4);
    base = px_cnt;
    m = 54'd3 << 51;
    run_frame(288, m, -1);
    LAT = 1'b1;
    wait_done();
    chk_frame("postrst", 2'b00, m, 6'd52, 6'd2, 234, base);
    chk("postrst.p0.row",  64'(px_r_arr[base]), 64'd0);
    chk("postrst.p0.slot", 64'(px_s_arr[base]), 64'd0);

    // Final edge and LAT rise land in the same CLK.
    base = px_cnt;
    run_frame(287, 54'h0, -1);
    SDAT = 3'b111;
    SCK  = 1'b0;
    tick(3);
    SCK = 1'b1;
    LAT = 1'b1;
    wait_done();
    chk_frame("coinc", 2'b00, 54'd1 << 53, 6'd54, 6'd1, 234, base);

    BLK = 1'b1;
    tick(4);
    chk("blank.on", 64'(blank), 64'd1);
    BLK = 1'b0;
    tick(4);
    chk("blank.off", 64'(blank), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
